// File: rtl/alu_muldiv_seq.sv
// Iterative WIDTHxWIDTH multiplier / restoring divider, one bit per clock, 17-cycle fixed latency.
// Optional two's-complement mode is enabled by defining MULDIV_SIGNED_EN.
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             z,
  output logic             c,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_stateNext;
  logic [CW-1:0]    r_cnt;
  logic             r_isDiv, r_negRes, r_negRem, r_sgnOp, r_bZero;
  logic [WIDTH-1:0] r_acc, r_mq, r_b;

  logic             w_signed, w_accept;
  logic [WIDTH-1:0] w_magA, w_magB;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_accNext, w_mqNext;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0] w_quo, w_rem, w_hiFinal, w_loFinal;
  logic             w_zFinal, w_cFinal;

`ifdef MULDIV_SIGNED_EN
  assign w_signed = op[1];
`else
  assign w_signed = op[1] & 1'b0;
`endif

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign stall    = (start & ~busy) | busy;
  assign w_accept = start & ~busy;

  // Operands enter the loop as magnitudes; signs are reapplied at completion.
  assign w_magA = (w_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_magB = (w_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  assign w_sum    = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
  assign w_trial  = {r_acc, r_mq[WIDTH-1]};
  assign w_borrow = (w_trial < {1'b0, r_b});
  assign w_diff   = w_trial[WIDTH-1:0] - r_b;

  // r_acc is the product high half or the partial remainder; r_mq the multiplier or dividend/quotient.
  always_comb begin
    w_accNext = w_sum[WIDTH:1];
    w_mqNext  = {w_sum[0], r_mq[WIDTH-1:1]};
    if (r_isDiv) begin
      w_accNext = w_borrow ? w_trial[WIDTH-1:0] : w_diff;
      w_mqNext  = {r_mq[WIDTH-2:0], ~w_borrow};
    end
  end

  assign w_prod    = {w_accNext, w_mqNext};
  assign w_prodFix = r_negRes ? -w_prod : w_prod;
  assign w_quo     = r_negRes ? -w_mqNext : w_mqNext;
  assign w_rem     = r_negRem ? -w_accNext : w_accNext;

  always_comb begin
    w_hiFinal = w_prodFix[2*WIDTH-1:WIDTH];
    w_loFinal = w_prodFix[WIDTH-1:0];
    w_zFinal  = (w_prodFix == '0);
    w_cFinal  = (w_prodFix[2*WIDTH-1:WIDTH] != '0);
    if (r_isDiv) begin
      w_hiFinal = w_rem;
      w_loFinal = w_quo;
      w_zFinal  = (w_quo == '0);
      // A positive signed quotient with the top bit set cannot be represented.
      w_cFinal  = r_bZero | (r_sgnOp & ~r_negRes & w_mqNext[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = RUN;
      RUN:     if (r_cnt == '0) w_stateNext = DONE;
      DONE:    w_stateNext = start ? RUN : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_isDiv     <= 1'b0;
      r_negRes    <= 1'b0;
      r_negRem    <= 1'b0;
      r_sgnOp     <= 1'b0;
      r_bZero     <= 1'b0;
      r_acc       <= '0;
      r_mq        <= '0;
      r_b         <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      z           <= 1'b0;
      c           <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_isDiv  <= op[0];
      r_sgnOp  <= w_signed;
      r_negRes <= w_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      r_negRem <= w_signed & in_a[WIDTH-1];
      r_bZero  <= op[0] & (in_b == '0);
      r_acc    <= '0;
      r_mq     <= op[0] ? w_magA : w_magB;
      r_b      <= op[0] ? w_magB : w_magA;
    end else if (busy) begin
      r_acc <= w_accNext;
      r_mq  <= w_mqNext;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        result_hi   <= w_hiFinal;
        result_lo   <= w_loFinal;
        z           <= w_zFinal;
        c           <= w_cFinal;
        div_by_zero <= r_bZero;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: random and directed ops checked against an arithmetic model.
// Signed cases are checked with MULDIV_SIGNED_EN defined; otherwise op[1] must be ignored.
module tb_alu_muldiv_seq;

  localparam int LATENCY = 17;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [15:0] in_a, in_b;
  logic        busy, done, stall, z, c, div_by_zero;
  logic [15:0] result_hi, result_lo;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        z;
    logic        c;
    logic        dbz;
    int          issue;
  } exp_t;

  exp_t sbQ[$];
  int   tests = 0;
  int   fails = 0;
  int   cycleCnt = 0;
  int   busyCnt = 0;

  alu_muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .stall(stall), .result_hi(result_hi), .result_lo(result_lo),
    .z(z), .c(c), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] p;
    int          sa, sb, q, r;
    bit          sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = $signed(a);
    sb = $signed(b);
    e.issue = 0;
    e.dbz = 1'b0;
    if (!o[0]) begin
      p = sgn ? 32'(sa * sb) : {16'b0, a} * {16'b0, b};
      e.hi = p[31:16];
      e.lo = p[15:0];
      e.z  = (p == 32'd0);
      e.c  = (p[31:16] != 16'd0);
    end else if (b == 16'd0) begin
      e.hi = a;
      e.lo = 16'hFFFF;
      e.z  = 1'b0;
      e.c  = 1'b1;
      e.dbz = 1'b1;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[15:0];
      e.hi = r[15:0];
      e.z  = (q[15:0] == 16'd0);
      e.c  = (q > 32767);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
      e.z  = (e.lo == 16'd0);
      e.c  = 1'b0;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_wait: busy stuck at 1, expected 0");
    end
    op = o;
    in_a = a;
    in_b = b;
    start = 1'b1;
    e = model(o, a, b);
    e.issue = cycleCnt;
    sbQ.push_back(e);
    #1 checkOutput("stall_on_start", stall, 1);
    @(negedge clk);
    start = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (sbQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sbQ.size());
    end
    @(negedge clk);
  endtask

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sbQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: done=1 with no operation pending, expected 0");
        end else begin
          e = sbQ.pop_front();
          checkOutput("result_hi", result_hi, e.hi);
          checkOutput("result_lo", result_lo, e.lo);
          checkOutput("z", z, e.z);
          checkOutput("c", c, e.c);
          checkOutput("div_by_zero", div_by_zero, e.dbz);
          checkOutput("latency", cycleCnt - e.issue, LATENCY);
          checkOutput("busy_cycles", busyCnt, LATENCY - 1);
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    in_a = 16'h0;
    in_b = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", {result_hi, result_lo}, 0);
    checkOutput("reset_flags", {z, c, div_by_zero}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_stall", stall, 0);

    applyStimulus(2'd0, 16'h1234, 16'h5678);
    checkOutput("run_busy", busy, 1);
    checkOutput("run_stall", stall, 1);
    applyStimulus(2'd0, 16'hFFFF, 16'hFFFF);
    applyStimulus(2'd0, 16'h0000, 16'h1234);
    applyStimulus(2'd1, 16'd1000, 16'd7);
    applyStimulus(2'd1, 16'h00AB, 16'h0000);

    // A start while busy must be dropped without disturbing the running op.
    applyStimulus(2'd0, 16'h00F0, 16'h0101);
    repeat (3) @(negedge clk);
    op = 2'd1;
    in_a = 16'h5555;
    in_b = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    applyStimulus(2'd3, 16'hFFF9, 16'h0002);
    applyStimulus(2'd2, 16'hFFFF, 16'hFFFF);
    applyStimulus(2'd3, 16'h8000, 16'hFFFF);
    applyStimulus(2'd1, 16'h8000, 16'hFFFF);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = (i % 8 == 3) ? 16'h0000 : 16'($urandom);
      if (ro == 2'd3 && rb == 16'h0000) rb = 16'h0001;
      if (i % 5 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(ro, ra, rb);
    end
    waitDrain();

    // Reset in the middle of a divide discards it entirely.
    applyStimulus(2'd1, 16'd1000, 16'd7);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    void'(sbQ.pop_back());
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_stall", stall, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_result", {result_hi, result_lo}, 0);
    checkOutput("midreset_flags", {z, c, div_by_zero}, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("post_reset_idle", busy, 0);

    applyStimulus(2'd0, 16'h0003, 16'h0005);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative 16x16 multiply and 16/16 divide sequencer that sits beside the CPU ALU in the execute stage. It accepts one operation at a time from the decode/issue logic and runs a shift-add or restoring-divide loop, one bit per clock. While running it holds the pipeline with a stall output, the same way data_hazard freezes the ALU. On completion it presents a 32-bit result plus z/c condition flags for the CC register.

Parameters:
WIDTH, 16, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only when busy=0
op  in  2  op[0]: 0=multiply, 1=divide; op[1]: signed (honoured only with MULDIV_SIGNED_EN)
in_a  in  16  multiplicand / dividend
in_b  in  16  multiplier / divisor
busy  out  1  loop running
done  out  1  one-cycle pulse, result valid
stall  out  1  start&~busy | busy; ORs into the pipeline hazard
result_hi  out  16  product[31:16] / remainder
result_lo  out  16  product[15:0] / quotient
z  out  1  result zero flag
c  out  1  mul: result_hi nonzero; div: divide-by-zero or overflow
div_by_zero  out  1  divide with in_b==0

Behaviour:
- Reset (any cycle, including mid-loop): state=IDLE; busy, done, z, c, div_by_zero=0; result_hi/lo=0; iteration counter=0; any in-flight operation is discarded.
- States: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
- IDLE: start=1 at edge k latches in_a, in_b, op; counter=WIDTH-1; state=RUN. in_a/in_b may change after edge k.
- RUN: one iteration per clock; busy=1 during cycles k+1..k+16; counter decrements; last iteration at counter==0 -> DONE.
- DONE (cycle k+17): busy=0, done=1 for exactly one cycle. result_hi/lo, z, c, div_by_zero are updated at the same edge and held until the next accepted start.
- start while busy=1: ignored, with no queueing. start in DONE cycle: accepted, so back-to-back throughput is 17 cycles.
- stall is combinational: high in the cycle start is presented while idle, and throughout RUN.
- Multiply: unsigned shift-add; 17-bit partial sum; {acc, multiplier} shifts right each cycle; full 32-bit product.
- Divide: restoring; 17-bit trial subtract of divisor from {rem, next dividend bit}; quotient bit=1 when no borrow.
- Divisor 0 needs no special path: the loop naturally yields quotient=0xFFFF, remainder=dividend. div_by_zero=1 and c=1.
- z = (result_lo==0) for divide, ({result_hi,result_lo}==0) for multiply.
- c = (result_hi!=0) for multiply. Latency is fixed at 17 cycles for all operands.

Optional Feature:
MULDIV_SIGNED_EN:
- Defined: op[1]=1 selects two's-complement operation. Operands are converted to magnitudes at latch. Signs are fixed at DONE capture, with no extra cycle:
  - product negated if a^b
  - quotient negated if a^b
  - remainder takes the dividend's sign
- Signed divide 0x8000/0xFFFF returns quotient 0x8000, remainder 0, c=1.
- Undefined: op[1] ignored; all operations unsigned.

Test Plan:
- Reset then start, op=0, a=0x1234, b=0x5678 -> busy cycles k+1..k+16; done at k+17; result=0x0626_0060, z=0, c=1.
- op=0, a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001, c=1; then a=0, b=0x1234 -> result 0, z=1, c=0.
- op=1, a=1000, b=7 -> result_lo=0x008E, result_hi=0x0006, div_by_zero=0. Then op=1, a=0x00AB, b=0 -> result_lo=0xFFFF, result_hi=0x00AB, div_by_zero=1, c=1.
- start pulsed again at k+5 with different operands -> ignored, first result unchanged. New start in DONE cycle -> second done exactly 17 cycles later.
- rst asserted at k+8 mid-divide -> next cycle busy=0, stall=0, outputs 0, no done pulse.
- MULDIV_SIGNED_EN defined: op=3, a=0xFFF9 (-7), b=2 -> quotient 0xFFFD, remainder 0xFFFF. op=2, a=0xFFFF, b=0xFFFF -> result 0x0000_0001. Macro undefined: same op=2 case -> 0xFFFE_0001.
